// File: rtl/adder_subtractor_reg.sv
// Registered WIDTH-bit two's-complement adder/subtractor.
// A single carry chain is shared by add and subtract: b is conditionally
// inverted and sub is injected as the carry-in. The chain is built from
// 4-bit carry-lookahead groups whose group carries ripple group-to-group.
// The result and its flags (carry-out/no-borrow, signed overflow, zero) are
// registered one cycle after the valid strobe.

// 4-bit carry-lookahead group: internal carries plus group propagate/generate.
module adder_subtractor_reg_cla4 (
    input  logic [3:0] p_i,
    input  logic [3:0] g_i,
    input  logic       ci_i,
    output logic [3:1] c_o,
    output logic       gp_o,
    output logic       gg_o
);

    // Flattened lookahead equations for the carries into bits 1..3 and the
    // group propagate/generate terms used by the inter-group chain.
    always_comb begin
        c_o[1] = g_i[0]
               | (p_i[0] & ci_i);
        c_o[2] = g_i[1]
               | (p_i[1] & g_i[0])
               | (p_i[1] & p_i[0] & ci_i);
        c_o[3] = g_i[2]
               | (p_i[2] & g_i[1])
               | (p_i[2] & p_i[1] & g_i[0])
               | (p_i[2] & p_i[1] & p_i[0] & ci_i);
        gp_o   = &p_i;
        gg_o   = g_i[3]
               | (p_i[3] & g_i[2])
               | (p_i[3] & p_i[2] & g_i[1])
               | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    end

endmodule

module adder_subtractor_reg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    // The chain is padded up to a whole number of 4-bit groups; padded bits
    // have p=g=0, so they never disturb the carry into bit WIDTH.
    localparam int unsigned NGRP = (WIDTH + 3) / 4;
    localparam int unsigned PW   = NGRP * 4;

    logic [WIDTH-1:0]  bx;
    logic [PW-1:0]     p;
    logic [PW-1:0]     g;
    logic [NGRP-1:0]   grp_p;
    logic [NGRP-1:0]   grp_g;
    logic [NGRP:0]     grp_c;
    logic [3*NGRP-1:0] inner_c;
    logic [PW:0]       carry;

    logic [WIDTH-1:0]  s_d;
    logic              cout_d;
    logic              ovf_d;
    logic              zero_d;

    logic [WIDTH-1:0]  s_q;
    logic              cout_q;
    logic              ovf_q;
    logic              zero_q;
    logic              valid_q;

    // Conditionally invert b for subtraction (ones' complement; +1 via carry-in).
    always_comb begin
        bx = b ^ {WIDTH{sub}};
    end

    // Per-bit propagate/generate, zero-padded to the group boundary.
    always_comb begin
        p = '0;
        g = '0;
        p[WIDTH-1:0] = a ^ bx;
        g[WIDTH-1:0] = a & bx;
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        adder_subtractor_reg_cla4 u_cla4 (
            .p_i  (p[4*k +: 4]),
            .g_i  (g[4*k +: 4]),
            .ci_i (grp_c[k]),
            .c_o  (inner_c[3*k +: 3]),
            .gp_o (grp_p[k]),
            .gg_o (grp_g[k])
        );
    end

    // Group carries ripple from the sub carry-in through each group's P/G.
    always_comb begin
        grp_c    = '0;
        grp_c[0] = sub;
        for (int unsigned k = 0; k < NGRP; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
    end

    // Assemble the per-bit carry-in vector from group and in-group carries.
    always_comb begin
        carry = '0;
        for (int unsigned k = 0; k < NGRP; k++) begin
            carry[4*k]     = grp_c[k];
            carry[4*k + 1] = inner_c[3*k];
            carry[4*k + 2] = inner_c[3*k + 1];
            carry[4*k + 3] = inner_c[3*k + 2];
        end
        carry[PW] = grp_c[NGRP];
    end

    // Sum bits and flags derived from the shared carry chain.
    always_comb begin
        s_d    = p[WIDTH-1:0] ^ carry[WIDTH-1:0];
        cout_d = carry[WIDTH];
        ovf_d  = (a[WIDTH-1] == bx[WIDTH-1]) && (s_d[WIDTH-1] != a[WIDTH-1]);
        zero_d = ~|s_d;
    end

    // Result registers load only on a valid strobe, so idle-cycle inputs
    // (including X) never reach them; out_valid tracks the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                s_q    <= s_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_adder_subtractor_reg.sv
// Self-checking bench for adder_subtractor_reg (WIDTH=64): directed cases
// from the arithmetic definition plus randomized traffic checked against a
// wide-integer reference model.
module tb_adder_subtractor_reg;

    localparam int unsigned W = 64;
    localparam logic signed [W+1:0] SMAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SMIN = {3'b111, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic [W-1:0] s;
    logic         cout;
    logic         overflow;
    logic         zero;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // reference model state
    logic         m_v;
    logic [W-1:0] m_s;
    logic         m_c;
    logic         m_o;
    logic         m_z;

    always #5 clk = ~clk;

    adder_subtractor_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .s         (s),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_v = 1'b0; m_s = '0; m_c = 1'b0; m_o = 1'b0; m_z = 1'b0;
    endtask

    // Plain arithmetic: unsigned wide sum/difference and signed range test.
    task automatic model_step(input logic v, input logic [W-1:0] av,
                              input logic [W-1:0] bv, input logic sv);
        logic [W:0]          ext;
        logic signed [W+1:0] sa, sb, sres;
        if (!v) begin
            m_v = 1'b0;
            return;
        end
        sa = $signed(av);
        sb = $signed(bv);
        if (!sv) begin
            ext  = {1'b0, av} + {1'b0, bv};
            m_s  = ext[W-1:0];
            m_c  = ext[W];
            sres = sa + sb;
        end else begin
            m_s  = av - bv;
            m_c  = (av >= bv);
            sres = sa - sb;
        end
        m_o = (sres > SMAX) || (sres < SMIN);
        m_z = (m_s == '0);
        m_v = 1'b1;
    endtask

    // Drive one cycle at negedge, advance past the sampling edge, update model.
    task automatic apply(input logic v, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic sv);
        @(negedge clk);
        in_valid = v;
        if (v) begin
            a = av; b = bv; sub = sv;
        end else begin
            a = 'x; b = 'x; sub = 1'bx;
        end
        @(posedge clk);
        model_step(v, av, bv, sv);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1; a = 64'd5; b = 64'd3; sub = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, cout, overflow, zero, s} !== {4'b0000, 64'd0}) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got v=%b c=%b o=%b z=%b s=%h, expected all zero",
                         i, out_valid, cout, overflow, zero, s);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_basic_add();
        apply(1'b1, 64'd100, 64'd50, 1'b0);
        n_checks++;
        if ({out_valid, cout, overflow, zero, s} !== {4'b1000, 64'd150}) begin
            n_fail++;
            $display("FAIL basic_add: got v=%b c=%b o=%b z=%b s=%0d, expected v=1 c=0 o=0 z=0 s=150",
                     out_valid, cout, overflow, zero, s);
        end
    endtask

    task automatic test_sub_back_to_back();
        apply(1'b1, 64'd50000, 64'd20000, 1'b1);
        n_checks++;
        if ({out_valid, cout, overflow, zero, s} !== {4'b1100, 64'd30000}) begin
            n_fail++;
            $display("FAIL sub_b2b_first: got v=%b c=%b o=%b z=%b s=%0d, expected v=1 c=1 o=0 z=0 s=30000",
                     out_valid, cout, overflow, zero, s);
        end
        apply(1'b1, 64'd987654, 64'd123456, 1'b1);
        n_checks++;
        if ({out_valid, cout, overflow, zero, s} !== {4'b1100, 64'd864198}) begin
            n_fail++;
            $display("FAIL sub_b2b_second: got v=%b c=%b o=%b z=%b s=%0d, expected v=1 c=1 o=0 z=0 s=864198",
                     out_valid, cout, overflow, zero, s);
        end
    endtask

    task automatic test_equal_and_borrow();
        apply(1'b1, 64'd1000000, 64'd1000000, 1'b1);
        n_checks++;
        if ({out_valid, cout, overflow, zero, s} !== {4'b1101, 64'd0}) begin
            n_fail++;
            $display("FAIL equal_sub: got v=%b c=%b o=%b z=%b s=%0d, expected v=1 c=1 o=0 z=1 s=0",
                     out_valid, cout, overflow, zero, s);
        end
        apply(1'b1, 64'd123456789, 64'd987654321, 1'b1);
        n_checks++;
        if ({out_valid, cout, overflow, zero, s} !== {4'b1000, 64'd18446744072845354084}) begin
            n_fail++;
            $display("FAIL borrow_sub: got v=%b c=%b o=%b z=%b s=%0d, expected v=1 c=0 o=0 z=0 s=18446744072845354084",
                     out_valid, cout, overflow, zero, s);
        end
    endtask

    task automatic test_corners();
        apply(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        n_checks++;
        if ({out_valid, cout, overflow, zero, s} !== {4'b1101, 64'd0}) begin
            n_fail++;
            $display("FAIL corner_wrap: got v=%b c=%b o=%b z=%b s=%h, expected v=1 c=1 o=0 z=1 s=0",
                     out_valid, cout, overflow, zero, s);
        end
        apply(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        n_checks++;
        if ({out_valid, cout, overflow, zero, s} !== {4'b1010, 64'h8000_0000_0000_0000}) begin
            n_fail++;
            $display("FAIL corner_pos_ovf: got v=%b c=%b o=%b z=%b s=%h, expected v=1 c=0 o=1 z=0 s=8000000000000000",
                     out_valid, cout, overflow, zero, s);
        end
        apply(1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        n_checks++;
        if ({out_valid, cout, overflow, zero, s} !== {4'b1110, 64'h7FFF_FFFF_FFFF_FFFF}) begin
            n_fail++;
            $display("FAIL corner_neg_ovf: got v=%b c=%b o=%b z=%b s=%h, expected v=1 c=1 o=1 z=0 s=7fffffffffffffff",
                     out_valid, cout, overflow, zero, s);
        end
    endtask

    task automatic test_hold_and_reset();
        apply(1'b1, 64'd1000000000, 64'd999999999, 1'b0);
        n_checks++;
        if ({out_valid, cout, overflow, zero, s} !== {4'b1000, 64'd1999999999}) begin
            n_fail++;
            $display("FAIL hold_result: got v=%b c=%b o=%b z=%b s=%0d, expected v=1 c=0 o=0 z=0 s=1999999999",
                     out_valid, cout, overflow, zero, s);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, '0, '0, 1'b0);
            n_checks++;
            if ({out_valid, cout, overflow, zero, s} !== {4'b0000, 64'd1999999999}) begin
                n_fail++;
                $display("FAIL hold_idle[%0d]: got v=%b c=%b o=%b z=%b s=%0d, expected v=0 c=0 o=0 z=0 s=1999999999",
                         i, out_valid, cout, overflow, zero, s);
            end
        end
        // reset asserted mid-cycle, together with a valid operation
        @(negedge clk);
        in_valid = 1'b1; a = 64'd77; b = 64'd11; sub = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({out_valid, cout, overflow, zero, s} !== {4'b0000, 64'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b c=%b o=%b z=%b s=%h, expected all zero",
                     out_valid, cout, overflow, zero, s);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, cout, overflow, zero, s} !== {4'b0000, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_discard: got v=%b c=%b o=%b z=%b s=%h, expected all zero",
                     out_valid, cout, overflow, zero, s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, cout, overflow, zero, s} !== {4'b0000, 64'd0}) begin
            n_fail++;
            $display("FAIL no_stale_after_reset: got v=%b c=%b o=%b z=%b s=%h, expected all zero",
                     out_valid, cout, overflow, zero, s);
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic test_random();
        logic         v, sv;
        logic [W-1:0] av, bv;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            sv = $urandom_range(0, 1);
            av = pick_operand();
            bv = ($urandom_range(0, 7) == 0) ? av : pick_operand();
            apply(v, av, bv, sv);
            n_checks++;
            if ({out_valid, cout, overflow, zero, s} !== {m_v, m_c, m_o, m_z, m_s}) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h sub=%b vin=%b: got v=%b c=%b o=%b z=%b s=%h, expected v=%b c=%b o=%b z=%b s=%h",
                         i, av, bv, sv, v, out_valid, cout, overflow, zero, s,
                         m_v, m_c, m_o, m_z, m_s);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
        model_reset();
        test_reset();
        test_basic_add();
        test_sub_back_to_back();
        test_equal_and_borrow();
        test_corners();
        test_hold_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_subtractor_reg.md
Name:
adder_subtractor_reg

Overview:
- Registered WIDTH-bit two's-complement adder/subtractor with a carry-out/no-borrow flag, a signed-overflow flag and a zero flag.
- Used as a datapath arithmetic primitive.
- Operands and the add/sub control are sampled on a valid strobe; the result appears one clock later with a matching valid.
- The arithmetic core is a single carry chain: b is conditionally inverted and sub is injected as carry-in.

Parameters:
- WIDTH, 64, operand and result width in bits (legal range 8..128).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- in_valid  input  1  operands a, b and sub are valid this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  s and the flags hold a new result this cycle.
- s  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- overflow  output  1  signed (two's-complement) overflow.
- zero  output  1  s == 0.

Behaviour:
- Core (combinational):
  - bx = b XOR {WIDTH{sub}}.
  - {c, r} = a + bx + sub, computed as a (WIDTH+1)-bit sum.
- Flags:
  - cout = c, with no inversion.
    - Add: cout=1 on unsigned wrap.
    - Sub: cout=1 when a >= b unsigned (no borrow); cout=0 when a borrow occurs.
  - overflow = (a[MSB] == bx[MSB]) && (r[MSB] != a[MSB]).
  - zero = (r == 0).
- Latency:
  - Exactly 1 cycle.
  - On a rising edge with in_valid=1, register s, cout, overflow and zero from the core, and set out_valid=1.
- Idle cycles:
  - On a rising edge with in_valid=0, set out_valid=0.
  - s, cout, overflow and zero hold their previous values.
- Throughput: one operation per cycle; back-to-back in_valid is supported with no bubbles.
- No backpressure: the downstream stage must accept every out_valid pulse.
- Reset:
  - While rst_n=0, asynchronously force s=0, cout=0, overflow=0, zero=0 and out_valid=0.
  - Reset takes priority over in_valid.
  - An operation sampled in the same cycle that reset asserts is discarded.
  - The first operation after release is sampled at the first rising edge with rst_n=1 and in_valid=1.
- Inputs are don't-care when in_valid=0, and X on them must not propagate to the registers.
- Boundary: a=b with sub=1 yields s=0, cout=1, zero=1, overflow=0.
- Implementation:
  - Carry chain built from 4-bit carry-lookahead groups; group carries ripple between groups, or use a lookahead tree.
  - A behavioural "+" is not permitted for the core.
  - The result must match the arithmetic definition above bit-exactly.

Test Plan:
- Reset and basic add:
  - Stimulus: hold rst_n=0 two cycles, then release; in_valid=1, a=100, b=50, sub=0.
  - Required: all outputs 0 during reset; next cycle out_valid=1, s=150, cout=0, overflow=0, zero=0.
- Subtraction without borrow, back-to-back:
  - Stimulus: a=50000, b=20000, sub=1, then a=987654, b=123456, sub=1 on consecutive cycles.
  - Required: results s=30000 and s=864198 on consecutive cycles, cout=1 for both.
- Equal operands and borrow:
  - Stimulus: a=b=1000000, sub=1, then a=123456789, b=987654321, sub=1.
  - Required: first result s=0, zero=1, cout=1.
  - Required: second result s=18446744072845354084, cout=0, overflow=0.
- Carry and overflow corners (WIDTH=64):
  - Stimulus: a=0xFFFF_FFFF_FFFF_FFFF, b=1, add; then a=0x7FFF_FFFF_FFFF_FFFF, b=1, add; then a=0x8000_0000_0000_0000, b=1, sub.
  - Required: s=0, cout=1, overflow=0, zero=1; then s=0x8000_0000_0000_0000, cout=0, overflow=1; then s=0x7FFF_FFFF_FFFF_FFFF, cout=1, overflow=1.
- Hold and mid-operation reset:
  - Stimulus: a=1000000000, b=999999999, add; then in_valid=0 for 3 cycles; then assert rst_n=0 asynchronously mid-cycle alongside in_valid=1.
  - Required: s=1999999999 with out_valid=1 for one cycle; s held with out_valid=0 during idle; all outputs 0 immediately on reset, with no stale result after release.
